// File: rtl/alu_batch_sequencer.sv
// rtl/alu_batch_sequencer.sv - runs a batch of ALU operations out of a dual-port RAM
// Optional opcode range check: define ALU_SEQ_OPCHK_EN.
module alu_batch_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 5,
  parameter int SRC_BASE = 0,
  parameter int OP_BASE  = 100,
  parameter int DST_BASE = 200,
  parameter int MAX_OPS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        op_count,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_RD_OP, S_EXEC, S_WB, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] SRC_A = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] OP_A  = ADDR_W'(OP_BASE);
  localparam logic [ADDR_W-1:0] DST_A = ADDR_W'(DST_BASE);
  localparam logic [7:0]        MAX_K = 8'(MAX_OPS);

  state_t              state_q, state_d;
  logic [7:0]          k_q, k_d, k_inc;
  logic [7:0]          op_count_q, op_count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   addrb_q, addrb_d;
  logic                wea_q, wea_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [DATA_W-1:0]   dina_q, dina_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic                err_q, err_d;

  assign k_inc = k_q + 8'd1;

  // Operand pair k lives at SRC_BASE+2k (A) and SRC_BASE+2k+1 (B); wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pair_addr(input logic [7:0] idx, input logic odd);
    return SRC_A + ADDR_W'({idx, odd});
  endfunction

  // State and output registers; reset clears everything at once so an aborted batch never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      op_count_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addrb_q    <= '0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      op_count_q <= op_count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addrb_q    <= addrb_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-output logic; wea and done are single-cycle strobes by default.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    op_count_d = op_count_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    addrb_d    = addrb_q;
    wea_d      = 1'b0;
    addra_d    = addra_q;
    dina_d     = dina_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d        = '0;
          op_count_d = '0;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          addrb_d    = pair_addr(8'd0, 1'b0);
          state_d    = S_RD_A;
        end
      end
      S_RD_A: begin
        addrb_d = pair_addr(k_q, 1'b1);
        state_d = S_RD_B;
      end
      S_RD_B: begin
        // doutb holds operand A here; all-ones marks the end of the batch.
        if (doutb == '1) begin
          state_d = S_DONE;
        end else begin
          alu_a_d = doutb;
          addrb_d = OP_A + ADDR_W'(k_q);
          state_d = S_RD_OP;
        end
      end
      S_RD_OP: begin
        alu_b_d = doutb;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_op_d = doutb[OP_W-1:0];
        state_d  = S_WB;
`ifdef ALU_SEQ_OPCHK_EN
        if (doutb[DATA_W-1:OP_W] != '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_WB: begin
        wea_d      = 1'b1;
        addra_d    = DST_A + ADDR_W'(k_q);
        dina_d     = alu_out;
        k_d        = k_inc;
        op_count_d = op_count_q + 8'd1;
        addrb_d    = pair_addr(k_inc, 1'b0);
        state_d    = (k_inc == MAX_K) ? S_DONE : S_RD_A;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign op_count = op_count_q;
  assign addrb    = addrb_q;
  assign wea      = wea_q;
  assign addra    = addra_q;
  assign dina     = dina_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
`ifdef ALU_SEQ_OPCHK_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
